// File: rtl/axis_deadlock_watchdog.sv
// Kernel deadlock watchdog: declares a block once the stall condition has held for
// THRESHOLD consecutive cycles, and records a snapshot, the episode length and an event count.
//
// state   | meaning
// IDLE    | condition not present, qualification count at zero
// WATCH   | condition present, counting consecutive cycles toward THRESHOLD
// BLOCKED | kernel declared blocked, episode length accumulating
module axis_deadlock_watchdog #(
  parameter int NUM_AXIS  = 4,
  parameter int NUM_INST  = 1,
  parameter int THRESHOLD = 16,
  parameter int CNT_W     = 16,
  parameter int EVT_W     = 8
) (
  input  logic                kernel_monitor_clock,
  input  logic                kernel_monitor_reset,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic [NUM_AXIS-1:0] inst_idle_sigs,
  input  logic [NUM_INST-1:0] inst_block_sigs,
  input  logic                clear,
  output logic                block,
  output logic                block_pulse,
  output logic [NUM_AXIS-1:0] stall_snapshot,
  output logic [CNT_W-1:0]    stall_cycles,
  output logic [EVT_W-1:0]    block_events
);

  typedef enum logic [1:0] {IDLE, WATCH, BLOCKED} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                block_d, pulse_d;
  logic [NUM_AXIS-1:0] snap_d;
  logic [CNT_W-1:0]    cycles_d;
  logic [EVT_W-1:0]    events_d;

  logic [NUM_AXIS-1:0] stalled;
  logic                all_stuck;
  logic                cond;
  logic                enter;

  // A channel waiting on an idle instance is not a stall; all-idle means finished.
  assign stalled   = axis_block_sigs & ~inst_idle_sigs;
  assign all_stuck = (|stalled) & (&(stalled | inst_idle_sigs));
  assign cond      = (|inst_block_sigs) | all_stuck;

  always_ff @(posedge kernel_monitor_clock or negedge kernel_monitor_reset) begin
    if (!kernel_monitor_reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      block          <= 1'b0;
      block_pulse    <= 1'b0;
      stall_snapshot <= '0;
      stall_cycles   <= '0;
      block_events   <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      block          <= block_d;
      block_pulse    <= pulse_d;
      stall_snapshot <= snap_d;
      stall_cycles   <= cycles_d;
      block_events   <= events_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    block_d  = block;
    pulse_d  = 1'b0;
    snap_d   = stall_snapshot;
    cycles_d = stall_cycles;
    events_d = block_events;
    enter    = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        block_d = 1'b0;
        if (cond) begin
          if (THRESHOLD == 1) begin
            enter = 1'b1;
          end else begin
            state_d = WATCH;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      WATCH: begin
        if (!cond) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(THRESHOLD - 1)) begin
          enter = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      BLOCKED: begin
        if (cond) begin
          if (stall_cycles != {CNT_W{1'b1}}) cycles_d = stall_cycles + CNT_W'(1);
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
          block_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        block_d = 1'b0;
      end
    endcase

    if (enter) begin
      state_d  = BLOCKED;
      cnt_d    = '0;
      block_d  = 1'b1;
      pulse_d  = 1'b1;
      snap_d   = stalled;
      cycles_d = CNT_W'(1);
      if (block_events != {EVT_W{1'b1}}) events_d = block_events + EVT_W'(1);
    end

    // Clear wins over any transition, so an entry on the same edge leaves no trace.
    if (clear) begin
      state_d  = IDLE;
      cnt_d    = '0;
      block_d  = 1'b0;
      pulse_d  = 1'b0;
      snap_d   = '0;
      cycles_d = '0;
      events_d = '0;
    end
  end

endmodule

// File: tb/tb_axis_deadlock_watchdog.sv
// Scoreboard bench for axis_deadlock_watchdog: three instances cover the default,
// narrow-counter and single-cycle-threshold configurations.
module tb_axis_deadlock_watchdog;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance a: THRESHOLD=4, default widths
  logic [3:0] a_axis = '0, a_idle = 4'hF;
  logic [0:0] a_inst = '0;
  logic       a_clear = 1'b0;
  logic       a_block, a_pulse;
  logic [3:0] a_snap;
  logic [15:0] a_cyc;
  logic [7:0] a_evt;

  // Instance b: THRESHOLD=4, CNT_W=4
  logic [3:0] b_axis = '0, b_idle = 4'hF;
  logic [0:0] b_inst = '0;
  logic       b_clear = 1'b0;
  logic       b_block, b_pulse;
  logic [3:0] b_snap;
  logic [3:0] b_cyc;
  logic [7:0] b_evt;

  // Instance c: THRESHOLD=1, EVT_W=2
  logic [3:0] c_axis = '0, c_idle = 4'hF;
  logic [0:0] c_inst = '0;
  logic       c_clear = 1'b0;
  logic       c_block, c_pulse;
  logic [3:0] c_snap;
  logic [15:0] c_cyc;
  logic [1:0] c_evt;

  axis_deadlock_watchdog #(.NUM_AXIS(4), .NUM_INST(1), .THRESHOLD(4), .CNT_W(16), .EVT_W(8)) u_a (
    .kernel_monitor_clock(clk), .kernel_monitor_reset(rst_n),
    .axis_block_sigs(a_axis), .inst_idle_sigs(a_idle), .inst_block_sigs(a_inst), .clear(a_clear),
    .block(a_block), .block_pulse(a_pulse), .stall_snapshot(a_snap),
    .stall_cycles(a_cyc), .block_events(a_evt));

  axis_deadlock_watchdog #(.NUM_AXIS(4), .NUM_INST(1), .THRESHOLD(4), .CNT_W(4), .EVT_W(8)) u_b (
    .kernel_monitor_clock(clk), .kernel_monitor_reset(rst_n),
    .axis_block_sigs(b_axis), .inst_idle_sigs(b_idle), .inst_block_sigs(b_inst), .clear(b_clear),
    .block(b_block), .block_pulse(b_pulse), .stall_snapshot(b_snap),
    .stall_cycles(b_cyc), .block_events(b_evt));

  axis_deadlock_watchdog #(.NUM_AXIS(4), .NUM_INST(1), .THRESHOLD(1), .CNT_W(16), .EVT_W(2)) u_c (
    .kernel_monitor_clock(clk), .kernel_monitor_reset(rst_n),
    .axis_block_sigs(c_axis), .inst_idle_sigs(c_idle), .inst_block_sigs(c_inst), .clear(c_clear),
    .block(c_block), .block_pulse(c_pulse), .stall_snapshot(c_snap),
    .stall_cycles(c_cyc), .block_events(c_evt));

  // Expected entry record: {snapshot[3:0], events[7:0]}
  logic [11:0] qa[$], qb[$], qc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitors: every entry pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && a_pulse) begin
      if (qa.size() == 0) check("a_unexpected_pulse", 1, 0);
      else begin
        logic [11:0] e;
        e = qa.pop_front();
        check("a_pulse_snapshot", 32'(a_snap), 32'(e[11:8]));
        check("a_pulse_events", 32'(a_evt), 32'(e[7:0]));
        check("a_pulse_cycles", 32'(a_cyc), 1);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_pulse) begin
      if (qb.size() == 0) check("b_unexpected_pulse", 1, 0);
      else begin
        logic [11:0] e;
        e = qb.pop_front();
        check("b_pulse_snapshot", 32'(b_snap), 32'(e[11:8]));
        check("b_pulse_events", 32'(b_evt), 32'(e[7:0]));
        check("b_pulse_cycles", 32'(b_cyc), 1);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && c_pulse) begin
      if (qc.size() == 0) check("c_unexpected_pulse", 1, 0);
      else begin
        logic [11:0] e;
        e = qc.pop_front();
        check("c_pulse_snapshot", 32'(c_snap), 32'(e[11:8]));
        check("c_pulse_events", 32'(c_evt), 32'(e[7:0]));
        check("c_pulse_cycles", 32'(c_cyc), 1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    check("reset_block", 32'(a_block), 0);
    check("reset_events", 32'(a_evt), 0);
    check("reset_cycles", 32'(a_cyc), 0);
    rst_n = 1'b1;
    cyc(2);

    // 1: channel 0 stalled, others idle, held 4 cycles
    a_axis = 4'b0001; a_idle = 4'b1110;
    qa.push_back({4'b0001, 8'd1});
    cyc(3);
    check("t1_no_block_early", 32'(a_block), 0);
    cyc(1);
    check("t1_block", 32'(a_block), 1);
    check("t1_pulse", 32'(a_pulse), 1);
    cyc(1);
    check("t1_pulse_one_cycle", 32'(a_pulse), 0);
    check("t1_cycles2", 32'(a_cyc), 2);
    a_axis = 4'b0000;
    cyc(1);
    check("t1_release", 32'(a_block), 0);
    check("t1_snap_hold", 32'(a_snap), 4'b0001);
    check("t1_cycles_hold", 32'(a_cyc), 2);
    check("t1_events", 32'(a_evt), 1);

    // 2: interrupted qualification restarts the count
    a_clear = 1'b1; cyc(1); a_clear = 1'b0;
    check("t2_clear_events", 32'(a_evt), 0);
    check("t2_clear_snap", 32'(a_snap), 0);
    a_axis = 4'b0001; cyc(2);
    a_axis = 4'b0000; cyc(1);
    a_axis = 4'b0001;
    qa.push_back({4'b0001, 8'd1});
    cyc(3);
    check("t2_no_block_after_drop", 32'(a_block), 0);
    cyc(1);
    check("t2_block", 32'(a_block), 1);
    check("t2_events", 32'(a_evt), 1);
    a_axis = 4'b0000; cyc(1);

    // 3: partial stall never qualifies; instance block does
    a_axis = 4'b0001; a_idle = 4'b1100;
    cyc(10);
    check("t3_partial_no_block", 32'(a_block), 0);
    a_inst = 1'b1;
    qa.push_back({4'b0001, 8'd2});
    cyc(3);
    check("t3_inst_early", 32'(a_block), 0);
    cyc(1);
    check("t3_inst_block", 32'(a_block), 1);
    check("t3_snap", 32'(a_snap), 4'b0001);
    a_inst = 1'b0; a_axis = 4'b0000; cyc(1);
    check("t3_release", 32'(a_block), 0);

    // 4: stall_cycles saturation on 4-bit counter
    b_axis = 4'b0001; b_idle = 4'b1110;
    qb.push_back({4'b0001, 8'd1});
    cyc(4);
    check("t4_block", 32'(b_block), 1);
    cyc(36);
    check("t4_saturate", 32'(b_cyc), 15);
    b_axis = 4'b0000; cyc(1);
    check("t4_release", 32'(b_block), 0);
    check("t4_cycles_hold", 32'(b_cyc), 15);

    // 5a: clear on the entry edge suppresses entry
    a_clear = 1'b1; cyc(1); a_clear = 1'b0;
    a_axis = 4'b0001; a_idle = 4'b1110;
    cyc(3);
    a_clear = 1'b1; cyc(1); a_clear = 1'b0;
    check("t5_clear_block", 32'(a_block), 0);
    check("t5_clear_pulse", 32'(a_pulse), 0);
    check("t5_clear_events", 32'(a_evt), 0);
    a_axis = 4'b0000; cyc(1);

    // 6: single-cycle threshold, event counter saturates at 3
    c_idle = 4'b1110;
    for (int i = 1; i <= 5; i++) begin
      c_axis = 4'b0001;
      qc.push_back({4'b0001, 8'((i > 3) ? 3 : i)});
      cyc(1);
      check("t6_block", 32'(c_block), 1);
      c_axis = 4'b0000;
      cyc(1);
      check("t6_release", 32'(c_block), 0);
    end
    check("t6_events_sat", 32'(c_evt), 3);

    // 5b: async reset mid-episode
    a_axis = 4'b0001; a_idle = 4'b1110;
    qa.push_back({4'b0001, 8'd1});
    cyc(6);
    check("t5_pre_reset_block", 32'(a_block), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_block", 32'(a_block), 0);
    check("t5_async_events", 32'(a_evt), 0);
    check("t5_async_snap", 32'(a_snap), 0);
    check("t5_async_cycles", 32'(a_cyc), 0);
    check("t5_async_pulse", 32'(a_pulse), 0);
    a_axis = 4'b0000;
    cyc(1);
    rst_n = 1'b1;
    cyc(2);

    check("qa_drained", qa.size(), 0);
    check("qb_drained", qb.size(), 0);
    check("qc_drained", qc.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
